// File: rtl/ucie_sb_cfg_arbiter.sv
// Round-robin arbiter sharing the RDI sideband config channel; credit-gated, whole-message grants.
// Optional stall watchdog enabled by defining UCIE_SB_ARB_WDOG_EN.
module ucie_sb_cfg_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned DW       = 32,
    parameter int unsigned CRD_MAX  = 8,
    parameter int unsigned WDOG_CYC = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_arb_en,
    input  logic                           i_err_clr,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ-1:0]                req_last,
    input  logic [NREQ*DW-1:0]             req_data,
    output logic [NREQ-1:0]                req_ready,
    output logic [DW-1:0]                  lp_cfg,
    output logic                           lp_cfg_vld,
    input  logic                           pl_cfg_crd,
    output logic [$clog2(NREQ)-1:0]        o_grant_id,
    output logic                           o_busy,
    output logic [$clog2(CRD_MAX+1)-1:0]   o_crd_cnt,
    output logic                           o_crd_ovf,
    output logic                           o_wdog_err
);

    localparam int unsigned GW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(CRD_MAX+1);

    generate
        if (NREQ < 2 || NREQ > 8 || WDOG_CYC < 1) begin : g_param_check
            $error("ucie_sb_cfg_arbiter: NREQ must be 2..8 and WDOG_CYC >= 1");
        end
    endgenerate

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   grant_id;
    logic [GW-1:0]   grant_sel;
    logic [GW-1:0]   grant_inc;
    logic [GW-1:0]   scan_idx;
    logic [GW:0]     scan_sum;
    logic            grant_found;
    logic [DW-1:0]   data_arr [NREQ];
    logic [CW-1:0]   crd_cnt;
    logic            has_credit;
    logic            accept;
    logic            accept_last;
    logic            abort;
    logic            crd_ovf;
    logic            wdog_err;
    logic            lp_vld;
    logic [DW-1:0]   lp_data;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = rr_ptr;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (GW+1)'(k);
            if (scan_sum >= (GW+1)'(NREQ))
                scan_sum = scan_sum - (GW+1)'(NREQ);
            scan_idx = scan_sum[GW-1:0];
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_sel   = scan_idx;
            end
        end
    end

    assign grant_inc   = (grant_id == GW'(NREQ-1)) ? '0 : grant_id + GW'(1);
    assign has_credit  = (crd_cnt != '0);
    assign accept      = (state == XFER) && has_credit && req_valid[grant_id];
    assign accept_last = accept && req_last[grant_id];

    always_comb begin
        req_ready = '0;
        if (state == XFER && has_credit)
            req_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_arb_en && grant_found) state_nxt = XFER;
            XFER: if (accept_last || abort)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            lp_data  <= '0;
            lp_vld   <= 1'b0;
        end else begin
            lp_vld <= accept;
            if (accept)
                lp_data <= data_arr[grant_id];
            if (state == IDLE && i_arb_en && grant_found)
                grant_id <= grant_sel;
            if (accept_last || abort)
                rr_ptr <= grant_inc;
        end
    end

    // Simultaneous accept and credit return cancel; a return at CRD_MAX is an overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crd_cnt <= CW'(CRD_MAX);
            crd_ovf <= 1'b0;
        end else begin
            if (accept && !pl_cfg_crd)
                crd_cnt <= crd_cnt - CW'(1);
            else if (pl_cfg_crd && !accept && crd_cnt != CW'(CRD_MAX))
                crd_cnt <= crd_cnt + CW'(1);

            if (pl_cfg_crd && !accept && crd_cnt == CW'(CRD_MAX))
                crd_ovf <= 1'b1;
            else if (i_err_clr)
                crd_ovf <= 1'b0;
        end
    end

`ifdef UCIE_SB_ARB_WDOG_EN
    localparam int unsigned WW = $clog2(WDOG_CYC+1);
    logic [WW-1:0] wdog_cnt;

    assign abort = (state == XFER) && !accept && (wdog_cnt == WW'(WDOG_CYC-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (state != XFER || accept || abort)
                wdog_cnt <= '0;
            else
                wdog_cnt <= wdog_cnt + WW'(1);

            if (abort)
                wdog_err <= 1'b1;
            else if (i_err_clr)
                wdog_err <= 1'b0;
        end
    end
`else
    assign abort    = 1'b0;
    assign wdog_err = 1'b0;
`endif

    assign lp_cfg     = lp_data;
    assign lp_cfg_vld = lp_vld;
    assign o_grant_id = grant_id;
    assign o_busy     = (state == XFER);
    assign o_crd_cnt  = crd_cnt;
    assign o_crd_ovf  = crd_ovf;
    assign o_wdog_err = wdog_err;

endmodule
